// File: rtl/seq_ram_arbiter_pkg.sv
// Shared constants and types for the sequence RAM port arbiter.
// Requester indices match the bit order of the req/we/addr/wdata vectors.
package seq_ram_arbiter_pkg;

    localparam int unsigned NREQ       = 3;
    localparam int unsigned REQ_SEQ    = 0;
    localparam int unsigned REQ_GAME   = 1;
    localparam int unsigned REQ_SCORE  = 2;

    localparam int unsigned SEQ_ADDR_W = 5;
    localparam int unsigned SEQ_DATA_W = 4;

    typedef logic [1:0] req_idx_t;

    typedef enum logic [1:0] {
        OWN_SEQ   = 2'd0,
        OWN_GAME  = 2'd1,
        OWN_SCORE = 2'd2,
        OWN_IDLE  = 2'd3
    } owner_e;

    typedef struct packed {
        logic     vld;
        req_idx_t idx;
    } rd_tag_t;

    function automatic req_idx_t next_idx(input req_idx_t i);
        return (i >= req_idx_t'(NREQ - 1)) ? '0 : i + 2'd1;
    endfunction

    function automatic logic [NREQ-1:0] idx_onehot(input req_idx_t i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i < req_idx_t'(NREQ)) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/seq_ram_arbiter_rr_pick.sv
// Combinational 3-way round-robin picker: first set, non-excluded request
// found scanning upward (with wrap) from the start index.
module rr_pick
    import seq_ram_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  req_idx_t        start,
    input  logic [NREQ-1:0] excl,
    output logic            valid,
    output req_idx_t        idx
);

    logic [NREQ-1:0] cand;
    req_idx_t        cur;

    always_comb begin
        cand  = req & ~excl;
        valid = 1'b0;
        idx   = '0;
        cur   = start;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!valid && cand[cur]) begin
                valid = 1'b1;
                idx   = cur;
            end
            cur = next_idx(cur);
        end
    end

endmodule

// File: rtl/seq_ram_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the single sequence RAM port between
// the sequencer, game controller and score lookup; read data is tagged back to its issuer.
module seq_ram_arbiter
    import seq_ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = SEQ_ADDR_W,
    parameter int unsigned DATA_W    = SEQ_DATA_W,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*DATA_W-1:0] wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [DATA_W-1:0]      rdata,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]      ram_wdata,
    output logic                   ram_we,
    input  logic [DATA_W-1:0]      ram_q
);

    localparam int unsigned      CNT_W      = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    owner_e            owner_q, owner_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    req_idx_t          last_q, last_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_last_q, addr_last_d;
    logic [DATA_W-1:0] wdata_last_q, wdata_last_d;
    rd_tag_t           rd_pipe_q [RD_LAT];
    rd_tag_t           rd_pipe_d [RD_LAT];
    rd_tag_t           rd_tail;

    logic              owner_vld;
    req_idx_t          sel_idx;
    logic              beat;
    req_idx_t          pick_start;
    logic              pick_any_vld, pick_oth_vld;
    req_idx_t          pick_any_idx, pick_oth_idx;

    assign owner_vld  = (owner_q != OWN_IDLE);
    assign sel_idx    = owner_vld ? req_idx_t'(owner_q) : '0;
    assign beat       = owner_vld && req[sel_idx];
    assign pick_start = next_idx(last_q);

    rr_pick u_pick_any (
        .req   (req),
        .start (pick_start),
        .excl  ('0),
        .valid (pick_any_vld),
        .idx   (pick_any_idx)
    );

    // last_q always equals the current owner, so this scans from owner+1.
    rr_pick u_pick_oth (
        .req   (req),
        .start (pick_start),
        .excl  (gnt_q),
        .valid (pick_oth_vld),
        .idx   (pick_oth_idx)
    );

    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        count_d = count_q;
        if (!beat) begin
            count_d = '0;
            if (pick_any_vld) begin
                owner_d = owner_e'(pick_any_idx);
                last_d  = pick_any_idx;
            end else begin
                owner_d = OWN_IDLE;
            end
        end else if (count_q < BURST_LAST) begin
            count_d = count_q + 1'b1;
        end else begin
            // Burst limit reached: yield only if someone else is waiting.
            count_d = '0;
            if (pick_oth_vld) begin
                owner_d = owner_e'(pick_oth_idx);
                last_d  = pick_oth_idx;
            end
        end
        gnt_d = idx_onehot(req_idx_t'(owner_d));
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = addr_last_q;
        ram_wdata = wdata_last_q;
        if (beat) begin
            ram_we    = we[sel_idx];
            ram_addr  = addr[sel_idx*ADDR_W +: ADDR_W];
            ram_wdata = wdata[sel_idx*DATA_W +: DATA_W];
        end
        addr_last_d  = ram_addr;
        wdata_last_d = ram_wdata;
    end

    always_comb begin
        rd_pipe_d[0].vld = beat && !we[sel_idx];
        rd_pipe_d[0].idx = sel_idx;
        for (int unsigned k = 1; k < RD_LAT; k++) begin
            rd_pipe_d[k] = rd_pipe_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= OWN_IDLE;
            gnt_q        <= '0;
            last_q       <= req_idx_t'(REQ_SCORE);
            count_q      <= '0;
            addr_last_q  <= '0;
            wdata_last_q <= '0;
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                rd_pipe_q[k] <= '0;
            end
        end else begin
            owner_q      <= owner_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            count_q      <= count_d;
            addr_last_q  <= addr_last_d;
            wdata_last_q <= wdata_last_d;
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                rd_pipe_q[k] <= rd_pipe_d[k];
            end
        end
    end

    assign rd_tail = rd_pipe_q[RD_LAT-1];
    assign gnt     = gnt_q;
    assign rvalid  = rd_tail.vld ? idx_onehot(rd_tail.idx) : '0;
    assign rdata   = rd_tail.vld ? ram_q : '0;

endmodule
